// File: rtl/filt_pkg.sv
// Shared definitions for the FIR MAC sequencer: state encoding and default geometry.
package filt_pkg;

  localparam int N_DEF     = 24;
  localparam int TAPS_DEF  = 8;
  localparam int FRAC_DEF  = 12;
  localparam int CNT_W_DEF = $clog2(TAPS_DEF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/mac_delay_line.sv
// TAPS x N sample shift register; slot 0 holds the newest sample, read by tap index.
module mac_delay_line #(
  parameter int N     = 24,
  parameter int TAPS  = 8,
  parameter int IDX_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                shift_en,
  input  logic signed [N-1:0] din,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic signed [N-1:0] rd_data
);

  logic signed [N-1:0] taps_q [TAPS];
  logic signed [N-1:0] taps_d [TAPS];

  always_comb begin
    taps_d = taps_q;
    if (shift_en) begin
      taps_d[0] = din;
      for (int i = 1; i < TAPS; i++) taps_d[i] = taps_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) taps_q[i] <= '0;
    end else begin
      taps_q <= taps_d;
    end
  end

  assign rd_data = taps_q[rd_idx];

endmodule

// File: rtl/mac_sequencer.sv
// Time-shared FIR controller: one tap per cycle through an external multiplier/adder.
// Define MAC_SAT_EN to saturate y_out on overflow and expose sat_flag.
module mac_sequencer
  import filt_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int TAPS = TAPS_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [N-1:0]     x_in,
  output logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic signed [N-1:0]     coef_data,
  output logic signed [N-1:0]     mult_a,
  output logic signed [N-1:0]     mult_b,
  output logic signed [2*N-1:0]   sum_ext,
  input  logic signed [2*N-1:0]   suma_g,
  output logic signed [N-1:0]     y_out,
  output logic                    y_valid,
`ifdef MAC_SAT_EN
  output logic                    sat_flag,
`endif
  output logic                    busy
);

  localparam int CNT_W = $clog2(TAPS);

  function automatic logic signed [N-1:0] trunc_out(input logic signed [2*N-1:0] a);
    return a[FRAC+N-1:FRAC];
  endfunction

`ifdef MAC_SAT_EN
  // Result fits only if every bit from the output sign bit upward agrees.
  function automatic logic ovf(input logic signed [2*N-1:0] a);
    logic [N-FRAC:0] hi;
    hi = a[2*N-1:FRAC+N-1];
    return !((&hi) || !(|hi));
  endfunction

  function automatic logic signed [N-1:0] sat_out(input logic signed [2*N-1:0] a);
    if (!ovf(a)) return trunc_out(a);
    return a[2*N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  endfunction
`endif

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      k_q, k_d;
  logic signed [2*N-1:0] acc_q, acc_d;
  logic signed [N-1:0]   y_out_q, y_out_d;
  logic                  sat_q, sat_d;
  logic                  shift_en;
  logic signed [N-1:0]   tap_rd;
  logic                  last_tap;

  mac_delay_line #(
    .N    (N),
    .TAPS (TAPS),
    .IDX_W(CNT_W)
  ) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .shift_en(shift_en),
    .din     (x_in),
    .rd_idx  (k_q),
    .rd_data (tap_rd)
  );

  assign last_tap = (k_q == CNT_W'(TAPS - 1));

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    acc_d     = acc_q;
    y_out_d   = y_out_q;
    sat_d     = sat_q;
    shift_en  = 1'b0;
    coef_addr = '0;
    mult_a    = '0;
    mult_b    = '0;
    sum_ext   = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_en = 1'b1;
          acc_d    = '0;
          k_d      = '0;
          state_d  = S_MAC;
        end
      end
      S_MAC: begin
        coef_addr = k_q;
        mult_a    = tap_rd;
        mult_b    = coef_data;
        sum_ext   = acc_q;
        acc_d     = suma_g;
        if (last_tap) begin
          // Capture the output from the final sum so it is stable during OUT.
`ifdef MAC_SAT_EN
          y_out_d = sat_out(suma_g);
          sat_d   = ovf(suma_g);
`else
          y_out_d = trunc_out(suma_g);
          sat_d   = 1'b0;
`endif
          state_d = S_OUT;
        end else begin
          k_d = k_q + CNT_W'(1);
        end
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      y_out_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      y_out_q <= y_out_d;
      sat_q   <= sat_d;
    end
  end

  assign y_out   = y_out_q;
  assign y_valid = (state_q == S_OUT);
  assign busy    = (state_q != S_IDLE);
`ifdef MAC_SAT_EN
  assign sat_flag = y_valid && sat_q;
`endif

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer (TAPS=4) with behavioural multiplier, adder and coefficient ROM.
module tb_mac_sequencer;

  localparam int N    = 24;
  localparam int TAPS = 4;
  localparam int FRAC = 12;
  localparam int AW   = $clog2(TAPS);
  localparam longint YMAX = (64'sd1 <<< (N-1)) - 1;
  localparam longint YMIN = -(64'sd1 <<< (N-1));

  typedef struct {
    logic [N-1:0] y;
    logic         sat;
    int           cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic [N-1:0]   x_in = '0;
  logic [AW-1:0]  coef_addr;
  logic [N-1:0]   coef_data;
  logic [N-1:0]   mult_a, mult_b, y_out;
  logic [2*N-1:0] sum_ext, suma_g;
  logic signed [2*N-1:0] prod;
  logic           y_valid, busy;
`ifdef MAC_SAT_EN
  logic           sat_flag;
`endif

  logic signed [N-1:0] coef_rom [TAPS];
  logic signed [N-1:0] hist [$];
  exp_t                q [$];
  int                  cyc = 0;
  int                  last_acc = -1000;
  bit                  done = 0;
  int                  n_pass = 0;
  int                  n_chk = 0;

  assign coef_data = coef_rom[coef_addr];
  assign prod      = $signed(mult_a) * $signed(mult_b);
  assign suma_g    = sum_ext + prod;

  mac_sequencer #(.N(N), .TAPS(TAPS), .FRAC(FRAC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .x_in     (x_in),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .mult_a   (mult_a),
    .mult_b   (mult_b),
    .sum_ext  (sum_ext),
    .suma_g   (suma_g),
    .y_out    (y_out),
    .y_valid  (y_valid),
`ifdef MAC_SAT_EN
    .sat_flag (sat_flag),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: dot product of the newest TAPS accepted samples with the coefficients, mod 2^(2N).
  function automatic exp_t model_out();
    logic signed [2*N-1:0] a;
    longint s, c, v;
    exp_t e;
    a = '0;
    for (int i = 0; i < TAPS; i++) begin
      s = (i < hist.size()) ? longint'(hist[i]) : 64'sd0;
      c = longint'(coef_rom[i]);
      a = a + (2*N)'(s * c);
    end
    v = longint'(a) >>> FRAC;
    e.sat = 1'b0;
    e.y   = N'(v);
`ifdef MAC_SAT_EN
    if (v > YMAX) begin
      e.y = N'(YMAX); e.sat = 1'b1;
    end else if (v < YMIN) begin
      e.y = N'(YMIN); e.sat = 1'b1;
    end
`endif
    e.cyc = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: every comparison happens here, on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        chk("leftover_expected", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
      end
      if (!rst_n) begin
        chk("rst_y_out",     64'(y_out),     64'd0);
        chk("rst_y_valid",   64'(y_valid),   64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_coef_addr", 64'(coef_addr), 64'd0);
        chk("rst_mult_a",    64'(mult_a),    64'd0);
        chk("rst_mult_b",    64'(mult_b),    64'd0);
        chk("rst_sum_ext",   64'(sum_ext),   64'd0);
      end else begin
        chk("busy", 64'(busy), 64'((cyc > last_acc) && (cyc <= last_acc + TAPS + 1)));
        if (y_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_y_valid", 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            chk("y_out",   64'(y_out), 64'(e.y));
            chk("latency", 64'(cyc),   64'(e.cyc));
`ifdef MAC_SAT_EN
            chk("sat_flag", 64'(sat_flag), 64'(e.sat));
`endif
          end
        end else if (q.size() > 0 && cyc > q[0].cyc) begin
          chk("missing_y_valid", 64'd0, 64'd1);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    #1 rst_n = 1'b0;
    q.delete();
    hist.delete();
    last_acc = -1000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Pulse start for one cycle; the next issue starts 'gap' cycles later.
  task automatic issue(input logic signed [N-1:0] x, input int gap);
    exp_t e;
    @(posedge clk);
    #1;
    start = 1'b1;
    x_in  = x;
    if (cyc >= last_acc + TAPS + 2) begin
      last_acc = cyc;
      hist.push_front(x);
      if (hist.size() > TAPS) void'(hist.pop_back());
      e     = model_out();
      e.cyc = cyc + TAPS + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
    repeat ((gap < 2 ? 2 : gap) - 2) @(posedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
  endtask

  task automatic set_coefs(input int c0, input int c1, input int c2, input int c3);
    coef_rom[0] = N'(c0); coef_rom[1] = N'(c1);
    coef_rom[2] = N'(c2); coef_rom[3] = N'(c3);
  endtask

  initial begin
    set_coefs(4096, 2048, 1024, 512);
    do_reset();

    // Impulse response
    issue(24'sd4096, 6);
    issue(24'sd0, 6);
    issue(24'sd0, 6);
    issue(24'sd0, 6);
    drain();

    // DC gain
    do_reset();
    set_coefs(4096, 4096, 4096, 4096);
    for (int i = 0; i < 6; i++) issue(24'sd100, 6);
    drain();

    // Negative sample
    do_reset();
    set_coefs(4096, 0, 0, 0);
    issue(-24'sd5, 6);
    drain();

    // Start while busy is dropped; the follow-up output reveals the delay-line contents
    do_reset();
    set_coefs(4096, 2048, 1024, 512);
    issue(24'sd1000, 2);
    issue(24'sd3000, 6);
    issue(24'sd0, 6);
    drain();

    // Start exactly when OUT asserts, then on the first IDLE cycle
    issue(24'sd7, TAPS + 1);
    issue(24'sd9, 1);
    issue(24'sd11, 6);
    drain();

    // Overflow
    do_reset();
    set_coefs(4096, 4096, 4096, 4096);
    for (int i = 0; i < 4; i++) issue(24'sh7FFFFF, 6);
    drain();

    // Reset in the middle of MAC at k=3: no output for that sample
    issue(24'sd500, 5);
    do_reset();
    repeat (12) @(posedge clk);

    // Randomised runs, including starts that land while busy
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int t = 0; t < TAPS; t++) coef_rom[t] = N'($urandom);
      for (int i = 0; i < 30; i++) begin
        logic [N-1:0] xr;
        xr = N'($urandom);
        if (r == 0) xr = N'($signed(xr) >>> 8);
        issue($signed(xr), int'($urandom_range(2, 9)));
      end
      drain();
    end

    done = 1;
  end

endmodule
